// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache, 8 lines x 16 bytes over a 1 KiB fetch space.
// Latency: hit is combinational (0 cycles); a miss costs 3 + L edges for L memory-busy edges.
// Backpressure: busywaitinstr stalls the CPU from miss detection until the fetched line is installed.
// Build option: define INSTRUCTION_CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module instruction_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  PC,
  output logic [31:0]  INSTRUCTION,
  output logic         busywaitinstr,
  output logic         inst_mem_read,
  output logic [5:0]   inst_mem_address,
  input  logic [127:0] inst_mem_readdata,
  input  logic         inst_mem_busywait
`ifdef INSTRUCTION_CACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [7:0]     r_valid;
  logic [2:0]     r_tag_array [8];
  logic [127:0]   r_data      [8];
  logic [127:0]   r_fill_buf;
  logic [5:0]     r_addr;
  logic           r_seen_busy;

  logic [2:0]     w_tag;
  logic [2:0]     w_index;
  logic [1:0]     w_offset;
  logic           w_hit;
  logic           w_busy;
  logic           w_read;
  logic           w_start_fill;
  logic           w_capture;
  logic           w_pc_unused;

  assign w_tag       = PC[9:7];
  assign w_index     = PC[6:4];
  assign w_offset    = PC[3:2];
  assign w_pc_unused = ^{PC[31:10], PC[1:0]};

  assign w_hit       = r_valid[w_index] && (r_tag_array[w_index] == w_tag);
  assign INSTRUCTION = w_hit ? r_data[w_index][{w_offset, 5'b0} +: 32] : 32'h0;

  // Stall is masked by reset so the CPU can always reset its own PC.
  assign busywaitinstr    = RESET & w_busy;
  assign inst_mem_read    = w_read;
  assign inst_mem_address = r_addr;

  assign w_start_fill = (r_state == IDLE) && (w_state_nxt == MEM_READ);
  assign w_capture    = (r_state == MEM_READ) && r_seen_busy && !inst_mem_busywait;

  // Next-state and FSM outputs. A miss is tested as !w_hit inside an if, so an
  // unknown hit result falls to the else path and never starts a fill.
  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = !w_hit;
        if (!w_hit) w_state_nxt = MEM_READ;
      end
      MEM_READ: begin
        w_read = 1'b1;
        w_busy = 1'b1;
        if (r_seen_busy && !inst_mem_busywait) w_state_nxt = UPDATE;
      end
      UPDATE: begin
        w_busy      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, valid bits, latched block address and the memory-busy seen flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_addr      <= '0;
      r_seen_busy <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_fill) begin
        r_addr      <= PC[9:4];
        r_seen_busy <= 1'b0;
      end else if ((r_state == MEM_READ) && inst_mem_busywait) begin
        r_seen_busy <= 1'b1;
      end
      if (r_state == UPDATE) r_valid[r_addr[2:0]] <= 1'b1;
    end
  end

  // Data path: capture the returned block, then install it at the latched index.
  always_ff @(posedge CLK) begin
    if (w_capture) r_fill_buf <= inst_mem_readdata;
    if (r_state == UPDATE) begin
      r_data[r_addr[2:0]]      <= r_fill_buf;
      r_tag_array[r_addr[2:0]] <= r_addr[5:3];
    end
  end

`ifdef INSTRUCTION_CACHE_STATS_EN
  // Saturating hit/miss counters; a hit in IDLE always has busywaitinstr low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if ((r_state == IDLE) && w_hit && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      if (w_start_fill && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: directed fetch sequences against a cycle-level cache model.
// Latency: model predicts L+3 stall edges per miss for the bench memory latency L.
// Backpressure: the bench CPU advances PC only after busywaitinstr is seen low.
`timescale 1ns/1ps
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [31:0]  PC = 32'h0;
  logic [31:0]  INSTRUCTION;
  logic         busywaitinstr;
  logic         inst_mem_read;
  logic [5:0]   inst_mem_address;
  logic [127:0] inst_mem_readdata = '0;
  logic         inst_mem_busywait = 1'b0;
`ifdef INSTRUCTION_CACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  instruction_cache dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .PC                (PC),
    .INSTRUCTION       (INSTRUCTION),
    .busywaitinstr     (busywaitinstr),
    .inst_mem_read     (inst_mem_read),
    .inst_mem_address  (inst_mem_address),
    .inst_mem_readdata (inst_mem_readdata),
    .inst_mem_busywait (inst_mem_busywait)
`ifdef INSTRUCTION_CACHE_STATS_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Memory contents: word w of block a holds the word address {a, w}.
  function automatic logic [127:0] block_of(input logic [5:0] a);
    logic [127:0] b;
    b = '0;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = {24'h0, a, w[1:0]};
    return b;
  endfunction

  // Instruction memory: busy for mem_lat edges after a request, then data for one cycle.
  int         mem_lat = 4;
  int         req_lat = 0;
  int         mem_cnt = 0;
  bit         mem_active = 1'b0;
  int         n_reads = 0;
  logic [5:0] last_addr = '0;
  logic [5:0] req_addr = '0;

  always @(posedge CLK) begin
    #1;
    if (!RESET) begin
      mem_active        = 1'b0;
      inst_mem_busywait = 1'b0;
      inst_mem_readdata = {4{32'hDEADBEEF}};
    end else if (mem_active) begin
      mem_cnt++;
      if (mem_cnt >= req_lat) begin
        inst_mem_busywait = 1'b0;
        inst_mem_readdata = block_of(req_addr);
        mem_active        = 1'b0;
      end
    end else begin
      inst_mem_readdata = {4{32'hDEADBEEF}};
      if (inst_mem_read) begin
        mem_active        = 1'b1;
        mem_cnt           = 0;
        req_lat           = mem_lat;
        inst_mem_busywait = 1'b1;
        req_addr          = inst_mem_address;
        last_addr         = inst_mem_address;
        n_reads++;
      end
    end
  end

  // Reference model: line table plus a countdown of edges left in the current fill.
  logic [7:0] m_valid = '0;
  logic [2:0] m_tag [8] = '{default: 3'd0};
  logic [5:0] m_addr = '0;
  int         fill_left = 0;
  int         m_hits = 0;
  int         m_miss = 0;

  always @(negedge CLK) begin
    logic [2:0]  idx;
    logic [2:0]  tg;
    logic        hit;
    logic [31:0] ei;
    logic        eb;
    logic        er;
    if (!RESET) begin
      m_valid   = '0;
      fill_left = 0;
      m_addr    = '0;
      m_hits    = 0;
      m_miss    = 0;
    end
    idx = PC[6:4];
    tg  = PC[9:7];
    hit = RESET && m_valid[idx] && (m_tag[idx] == tg);
    ei  = hit ? {24'h0, PC[9:2]} : 32'h0;
    eb  = RESET && ((fill_left != 0) || !hit);
    er  = RESET && (fill_left >= 2);
    check("instruction", INSTRUCTION, ei);
    check("busywaitinstr", busywaitinstr, eb);
    check("inst_mem_read", inst_mem_read, er);
    check("inst_mem_address", inst_mem_address, m_addr);
`ifdef INSTRUCTION_CACHE_STATS_EN
    check("hit_count", hit_count, (m_hits > 65535) ? 65535 : m_hits);
    check("miss_count", miss_count, (m_miss > 65535) ? 65535 : m_miss);
`endif
    if (RESET) begin
      if (fill_left == 0) begin
        if (hit) m_hits++;
        else begin
          m_miss++;
          m_addr    = PC[9:4];
          fill_left = mem_lat + 2;
        end
      end else begin
        fill_left--;
        if (fill_left == 0) begin
          m_valid[m_addr[2:0]] = 1'b1;
          m_tag[m_addr[2:0]]   = m_addr[5:3];
        end
      end
    end
  end

  // Count stall edges until busywaitinstr is seen low, with a bound.
  task automatic wait_ready(output int edges);
    edges = 0;
    @(negedge CLK);
    while (busywaitinstr && edges < 100) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end
    if (edges >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_ready: busywaitinstr still high after %0d edges, required low", edges);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input int exp_edges, input logic [31:0] exp_instr);
    int e;
    @(posedge CLK);
    #2;
    PC = pc;
    wait_ready(e);
    check($sformatf("stall_edges@%0h", pc), e, exp_edges);
    check($sformatf("instr@%0h", pc), INSTRUCTION, exp_instr);
  endtask

  initial begin
    int e;
    PC      = 32'h0;
    RESET   = 1'b0;
    mem_lat = 4;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", busywaitinstr, 1'b0);
    check("reset_read", inst_mem_read, 1'b0);
    check("reset_addr", inst_mem_address, 6'd0);
    check("reset_instr", INSTRUCTION, 32'h0);

    // Cold miss with L=4: 7 stall edges, one read of block 0.
    @(posedge CLK);
    #2 RESET = 1'b1;
    wait_ready(e);
    check("cold_stall_edges", e, 7);
    check("cold_instr", INSTRUCTION, 32'h0);
    check("cold_reads", n_reads, 1);
    check("cold_addr", last_addr, 6'd0);

    // Sequential hits in the filled line.
    fetch(32'h4, 0, 32'h1);
    fetch(32'h8, 0, 32'h2);
    fetch(32'hC, 0, 32'h3);
    check("seq_reads", n_reads, 1);
    @(posedge CLK);
    #1;
`ifdef INSTRUCTION_CACHE_STATS_EN
    check("stats_miss_count", miss_count, 16'd1);
    check("stats_hit_ge4", hit_count >= 16'd4, 1'b1);
`endif

    // Conflict eviction at index 0, L=2.
    mem_lat = 2;
    fetch(32'h080, 5, 32'd32);
    check("evict_addr", last_addr, 6'd8);
    fetch(32'h084, 0, 32'd33);
    fetch(32'h000, 5, 32'd0);
    check("evict_reads", n_reads, 3);
    check("refill_addr", last_addr, 6'd0);

    // Ignored PC bits.
    fetch(32'h400, 0, 32'd0);
    fetch(32'h40C, 0, 32'd3);
    fetch(32'h001, 0, 32'd0);
    fetch(32'hFFFF_F008, 0, 32'd2);
    check("ignored_reads", n_reads, 3);

    // Top line, L=3.
    mem_lat = 3;
    fetch(32'h3FC, 6, 32'h000000FF);
    check("top_addr", last_addr, 6'd63);
    fetch(32'h3F0, 0, 32'h000000FC);

    // Reset on the second MEM_READ cycle, with data about to be captured.
    mem_lat = 1;
    @(posedge CLK);
    #2 PC = 32'h010;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("midfill_read_high", inst_mem_read, 1'b1);
    #1 RESET = 1'b0;
    #1;
    check("midfill_read_dropped", inst_mem_read, 1'b0);
    check("midfill_busy_dropped", busywaitinstr, 1'b0);
    check("midfill_addr_cleared", inst_mem_address, 6'd0);
    PC = 32'h0;
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b1;
    wait_ready(e);
    check("post_reset_stall_edges", e, 4);
    check("post_reset_instr", INSTRUCTION, 32'h0);
    fetch(32'h010, 4, 32'h4);
    fetch(32'h3F0, 4, 32'h000000FC);
    check("post_reset_reads", n_reads, 8);

`ifdef INSTRUCTION_CACHE_STATS_EN
    repeat (70000) @(posedge CLK);
    @(negedge CLK);
    check("stats_hit_saturated", hit_count, 16'hFFFF);
`endif

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
